div_unit: RTL and testbench



---
 rtl/div_unit.sv | 166 ++++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Sequential signed 32-bit divider (restoring, one quotient bit per cycle): LO = quotient, HI = remainder.
// Latency: DivDone registered 33 edges after the start edge; divide-by-zero pulse registered on the start edge.
// Backpressure: DivCtrl is ignored while DivBusy is high; the caller waits for DivDone/DivZero.
//
// Ports: clock/reset (synchronous, active-low); DivCtrl start, A dividend, B divisor;
//        HI/LO result registers; DivDone/DivZero one-cycle pulses; DivBusy high outside IDLE.
// Optional: define DIV_EARLY_OUT_EN to skip the iteration phase when |A| < |B|.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivDone,
    output logic             DivZero,
    output logic             DivBusy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_rem, w_rem_nxt;
    logic [WIDTH-1:0]   r_dvd, w_dvd_nxt;
    logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
    logic [WIDTH-1:0]   r_quot, w_quot_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0]   r_lo, w_lo_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_sign_q, w_sign_q_nxt;
    logic               r_sign_r, w_sign_r_nxt;
    logic               r_done, w_done_nxt;
    logic               r_zero, w_zero_nxt;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_rem_sh;
    logic               w_ge;
    logic               w_early;

    // Magnitudes: -0x80000000 wraps back to 0x80000000, which is the correct
    // unsigned magnitude, so the overflow case needs no special handling.
    assign w_abs_a  = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign w_abs_b  = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

    // The partial remainder is always below the divisor (at most 2^31), so the
    // shifted value still fits in WIDTH bits.
    assign w_rem_sh = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= r_dvs);

`ifdef DIV_EARLY_OUT_EN
    assign w_early  = (w_abs_a < w_abs_b);
`else
    assign w_early  = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_dvd_nxt    = r_dvd;
        w_dvs_nxt    = r_dvs;
        w_quot_nxt   = r_quot;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_cnt_nxt    = r_cnt;
        w_sign_q_nxt = r_sign_q;
        w_sign_r_nxt = r_sign_r;
        w_done_nxt   = 1'b0;
        w_zero_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (DivCtrl) begin
                    if (B == '0) begin
                        // HI/LO deliberately untouched on divide-by-zero.
                        w_done_nxt  = 1'b1;
                        w_zero_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_sign_q_nxt = A[WIDTH-1] ^ B[WIDTH-1];
                        w_sign_r_nxt = A[WIDTH-1];
                        w_dvs_nxt    = w_abs_b;
                        w_dvd_nxt    = w_abs_a;
                        w_quot_nxt   = '0;
                        w_cnt_nxt    = CNT_W'(WIDTH - 1);
                        if (w_early) begin
                            w_rem_nxt   = w_abs_a;
                            w_state_nxt = FIX;
                        end else begin
                            w_rem_nxt   = '0;
                            w_state_nxt = CALC;
                        end
                    end
                end
            end
            CALC: begin
                w_rem_nxt  = w_ge ? (w_rem_sh - r_dvs) : w_rem_sh;
                w_dvd_nxt  = {r_dvd[WIDTH-2:0], 1'b0};
                w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                if (r_cnt == '0) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_lo_nxt    = r_sign_q ? (~r_quot + WIDTH'(1)) : r_quot;
                w_hi_nxt    = r_sign_r ? (~r_rem + WIDTH'(1)) : r_rem;
                w_done_nxt  = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_quot   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_rem    <= w_rem_nxt;
            r_dvd    <= w_dvd_nxt;
            r_dvs    <= w_dvs_nxt;
            r_quot   <= w_quot_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sign_q <= w_sign_q_nxt;
            r_sign_r <= w_sign_r_nxt;
            r_done   <= w_done_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

    assign HI      = r_hi;
    assign LO      = r_lo;
    assign DivDone = r_done;
    assign DivZero = r_zero;
    assign DivBusy = (r_state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder vectors, latency,
// divide-by-zero, busy-start rejection, mid-operation reset and the early-out option.
// Latency is reported as the edge (start edge = 0) at which DivDone was registered.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivDone;
    logic        DivZero;
    logic        DivBusy;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clock   (clock),
        .reset   (reset),
        .DivCtrl (DivCtrl),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .DivDone (DivDone),
        .DivZero (DivZero),
        .DivBusy (DivBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one operation once the unit is idle and returns the DivDone edge,
    // the captured results, and checks that DivDone is a single-cycle pulse.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic z);
        int guard;
        guard = 0;
        while (DivBusy && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        @(negedge clock);
        A = a; B = b; DivCtrl = 1'b1;
        @(posedge clock); #1;          // edge 0
        DivCtrl = 1'b0;
        lat = -1;
        if (DivDone) lat = 0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clock); #1;
            if (DivDone) lat = k;
        end
        hi = HI; lo = LO; z = DivZero;
        @(posedge clock); #1;
        check({tag, "_pulse"}, {31'd0, DivDone}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rhi, rlo;
    logic        rz;

    initial begin
        reset = 1'b0; DivCtrl = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hi",   HI, 32'd0);
        check("rst_lo",   LO, 32'd0);
        check("rst_done", {31'd0, DivDone}, 32'd0);
        check("rst_zero", {31'd0, DivZero}, 32'd0);
        check("rst_busy", {31'd0, DivBusy}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // 7 / 2 = 3 r 1
        do_op("p7d2", 32'd7, 32'd2, lat, rhi, rlo, rz);
        check("p7d2_lat", lat, 32'd33);
        check("p7d2_lo",  rlo, 32'h0000_0003);
        check("p7d2_hi",  rhi, 32'h0000_0001);
        check("p7d2_z",   {31'd0, rz}, 32'd0);

        // -7 / 2 = -3 r -1
        do_op("m7d2", 32'hFFFF_FFF9, 32'd2, lat, rhi, rlo, rz);
        check("m7d2_lat", lat, 32'd33);
        check("m7d2_lo",  rlo, 32'hFFFF_FFFD);
        check("m7d2_hi",  rhi, 32'hFFFF_FFFF);

        // 7 / -2 = -3 r 1
        do_op("p7dm2", 32'd7, 32'hFFFF_FFFE, lat, rhi, rlo, rz);
        check("p7dm2_lo", rlo, 32'hFFFF_FFFD);
        check("p7dm2_hi", rhi, 32'h0000_0001);

        // -100 / -7 = 14 r -2
        do_op("m100dm7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, rhi, rlo, rz);
        check("m100dm7_lo", rlo, 32'h0000_000E);
        check("m100dm7_hi", rhi, 32'hFFFF_FFFE);

        // 0x7FFFFFFF / 1
        do_op("max_d1", 32'h7FFF_FFFF, 32'd1, lat, rhi, rlo, rz);
        check("max_d1_lo", rlo, 32'h7FFF_FFFF);
        check("max_d1_hi", rhi, 32'h0000_0000);

        // Overflow: INT_MIN / -1 wraps
        do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, lat, rhi, rlo, rz);
        check("ovf_lat", lat, 32'd33);
        check("ovf_lo",  rlo, 32'h8000_0000);
        check("ovf_hi",  rhi, 32'h0000_0000);
        check("ovf_z",   {31'd0, rz}, 32'd0);

        // Dividend 0
        do_op("zero_dvd", 32'd0, 32'd5, lat, rhi, rlo, rz);
`ifdef DIV_EARLY_OUT_EN
        check("zero_dvd_lat", lat, 32'd1);
`else
        check("zero_dvd_lat", lat, 32'd33);
`endif
        check("zero_dvd_lo", rlo, 32'd0);
        check("zero_dvd_hi", rhi, 32'd0);

        // Preload HI=1/LO=3, then divide by zero: pulse seen by edge 1, results held
        do_op("preload", 32'd7, 32'd2, lat, rhi, rlo, rz);
        check("preload_lo", rlo, 32'd3);
        while (DivBusy) begin @(posedge clock); #1; end
        @(negedge clock);
        A = 32'd5; B = 32'd0; DivCtrl = 1'b1;
        @(posedge clock); #1;          // edge 0
        DivCtrl = 1'b0;
        check("dz_done_e1", {31'd0, DivDone}, 32'd1);
        check("dz_zero_e1", {31'd0, DivZero}, 32'd1);
        check("dz_busy",    {31'd0, DivBusy}, 32'd1);
        @(posedge clock); #1;          // edge 1
        check("dz_done_e2", {31'd0, DivDone}, 32'd0);
        check("dz_zero_e2", {31'd0, DivZero}, 32'd0);
        check("dz_hi", HI, 32'd1);
        check("dz_lo", LO, 32'd3);

        // Busy start ignored: 100/3 with a 9/9 re-pulse at edge 5
        @(posedge clock); #1;
        @(negedge clock);
        A = 32'd100; B = 32'd3; DivCtrl = 1'b1;
        @(posedge clock); #1;          // edge 0
        DivCtrl = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            if (k == 5) begin A = 32'd9; B = 32'd9; DivCtrl = 1'b1; end
            @(posedge clock); #1;
            if (k == 5) DivCtrl = 1'b0;
            if (k == 2) check("busy_e2", {31'd0, DivBusy}, 32'd1);
            if (DivDone) lat = k;
        end
        check("ign_lat", lat, 32'd33);
        check("ign_lo",  LO, 32'd33);
        check("ign_hi",  HI, 32'd1);
        check("ign_z",   {31'd0, DivZero}, 32'd0);
        repeat (2) @(posedge clock);
        #1;

        // Reset at edge 10 aborts 100/3
        @(negedge clock);
        A = 32'd100; B = 32'd3; DivCtrl = 1'b1;
        @(posedge clock); #1;          // edge 0
        DivCtrl = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) reset = 1'b0;
            @(posedge clock); #1;
        end
        check("abort_hi",   HI, 32'd0);
        check("abort_lo",   LO, 32'd0);
        check("abort_busy", {31'd0, DivBusy}, 32'd0);
        check("abort_done", {31'd0, DivDone}, 32'd0);
        reset = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (DivDone && lat < 0) lat = k;
        end
        check("abort_no_done", lat, 32'hFFFF_FFFF);

        // New start after abort: 20 / -6 = -3 r 2
        do_op("post_rst", 32'd20, 32'hFFFF_FFFA, lat, rhi, rlo, rz);
        check("post_rst_lat", lat, 32'd33);
        check("post_rst_lo",  rlo, 32'hFFFF_FFFD);
        check("post_rst_hi",  rhi, 32'h0000_0002);

        // Back-to-back: accepted on the edge right after DONE
        do_op("b2b", 32'd45, 32'd7, lat, rhi, rlo, rz);
        check("b2b_lat", lat, 32'd33);
        check("b2b_lo",  rlo, 32'd6);
        check("b2b_hi",  rhi, 32'd3);

`ifdef DIV_EARLY_OUT_EN
        do_op("early", 32'd3, 32'd10, lat, rhi, rlo, rz);
        check("early_lat", lat, 32'd1);
        check("early_lo",  rlo, 32'd0);
        check("early_hi",  rhi, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
